// File: rtl/deint_pkg.sv
// Shared geometry and FSM state types for the 4x11 block deinterleaver front-end.
package deint_pkg;

    localparam int unsigned DEINT_ROWS       = 4;
    localparam int unsigned DEINT_COLS       = 11;
    localparam int unsigned DEINT_FRAME_BITS = 44;
    localparam int unsigned COL_W            = 4;
    localparam int unsigned ROW_W            = 2;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/deinterleave_frame_ctrl_deinterleaver.sv
// Combinational 44-bit deinterleave permutation: interleaved bit 4c+r lands on bit 11r+c.
module deinterleaver_44bit
    import deint_pkg::*;
(
    input  logic [DEINT_FRAME_BITS-1:0] in_bits,
    output logic [DEINT_FRAME_BITS-1:0] out_bits
);

    always_comb begin
        out_bits = '0;
        for (int unsigned r = 0; r < DEINT_ROWS; r++) begin
            for (int unsigned c = 0; c < DEINT_COLS; c++) begin
                out_bits[r*DEINT_COLS + c] = in_bits[c*DEINT_ROWS + r];
            end
        end
    end

endmodule

// File: rtl/deinterleave_frame_ctrl.sv
// Double-buffered frame controller: fills 11 column beats, deinterleaves, drains 4 rows.
module deinterleave_frame_ctrl
    import deint_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DEINT_ROWS-1:0] in_data,
    input  logic                  frame_abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEINT_COLS-1:0] out_row,
    output logic [ROW_W-1:0]      out_row_idx,
    output logic                  out_last
);

    fill_state_t                 fill_q, fill_d;
    drain_state_t                drain_q, drain_d;
    logic [COL_W-1:0]            col_q, col_d, wr_col;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [DEINT_FRAME_BITS-1:0] fill_buf, drain_buf, deint_bits;
    logic                        out_hs, last_row_done, transfer, in_hs;

    deinterleaver_44bit u_deint (
        .in_bits  (fill_buf),
        .out_bits (deint_bits)
    );

    // Handshakes and the fill->drain transfer condition.
    always_comb begin
        out_hs        = (drain_q == DRAIN) && out_ready;
        last_row_done = out_hs && (row_q == ROW_W'(DEINT_ROWS - 1));
        transfer      = (fill_q == FULL) && !frame_abort &&
                        ((drain_q == IDLE) || last_row_done);
        in_ready      = !frame_abort && ((fill_q == FILL) || transfer);
        in_hs         = in_valid && in_ready;
    end

    // A beat accepted during a transfer starts the next frame at column 0.
    always_comb begin
        fill_d  = fill_q;
        col_d   = col_q;
        drain_d = drain_q;
        row_d   = row_q;
        wr_col  = (fill_q == FULL) ? '0 : col_q;

        if (frame_abort) begin
            fill_d = FILL;
            col_d  = '0;
        end else begin
            if (transfer) begin
                fill_d = FILL;
            end
            if (in_hs) begin
                if (wr_col == COL_W'(DEINT_COLS - 1)) begin
                    fill_d = FULL;
                    col_d  = '0;
                end else begin
                    col_d = wr_col + 1'b1;
                end
            end
        end

        if (out_hs) begin
            row_d = row_q + 1'b1;
            if (last_row_done) begin
                drain_d = IDLE;
            end
        end
        if (transfer) begin
            drain_d = DRAIN;
            row_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q    <= FILL;
            col_q     <= '0;
            drain_q   <= IDLE;
            row_q     <= '0;
            fill_buf  <= '0;
            drain_buf <= '0;
        end else begin
            fill_q  <= fill_d;
            col_q   <= col_d;
            drain_q <= drain_d;
            row_q   <= row_d;
            if (in_hs) begin
                fill_buf[DEINT_ROWS*wr_col +: DEINT_ROWS] <= in_data;
            end
            if (transfer) begin
                drain_buf <= deint_bits;
            end
        end
    end

    // Row outputs come straight from the drain buffer so they hold while stalled.
    always_comb begin
        out_valid   = (drain_q == DRAIN);
        out_row     = '0;
        out_row_idx = '0;
        out_last    = 1'b0;
        if (out_valid) begin
            out_row     = drain_buf[DEINT_COLS*row_q +: DEINT_COLS];
            out_row_idx = row_q;
            out_last    = (row_q == ROW_W'(DEINT_ROWS - 1));
        end
    end

endmodule

// File: tb/tb_deinterleave_frame_ctrl.sv
// Self-checking bench: frame-level reference model plus directed scenarios with literal rows.
module tb_deinterleave_frame_ctrl;

    typedef logic [3:0] beat_q_t[$];

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        frame_abort;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_row;
    logic [1:0]  out_row_idx;
    logic        out_last;

    deinterleave_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .frame_abort (frame_abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int stall_cnt = 0;

    // Reference model: beats collected so far, and rows of the frame being drained.
    int          fill_n = 0;
    logic [43:0] fbuf = '0;
    logic [10:0] mq[$];
    logic [10:0] got[$];
    logic        e_valid = 1'b0;
    logic        e_ready = 1'b0;
    logic        e_xfer  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    function automatic logic [43:0] deint(input logic [43:0] x);
        logic [43:0] y;
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 11; c++)
                y[11*r + c] = x[4*c + r];
        return y;
    endfunction

    // Compare outputs mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            e_valid = (mq.size() > 0);
            e_xfer  = (fill_n == 11) && !frame_abort &&
                      (mq.size() == 0 || (mq.size() == 1 && out_ready));
            e_ready = !frame_abort && (fill_n < 11 || e_xfer);
            chk("in_ready", in_ready, e_ready);
            chk("out_valid", out_valid, e_valid);
            if (e_valid) begin
                chk("out_row", out_row, mq[0]);
                chk("out_row_idx", out_row_idx, 32'(4 - mq.size()));
                chk("out_last", out_last, mq.size() == 1);
            end
            if (out_valid && out_ready) begin
                got.push_back(out_row);
                hs_cnt++;
            end
            if (in_valid && !in_ready) stall_cnt++;
        end
    end

    // Advance the model on each active edge.
    always @(posedge clk) begin
        logic [43:0] y;
        if (rst) begin
            fill_n = 0;
            mq.delete();
        end else begin
            if (e_valid && out_ready) void'(mq.pop_front());
            if (frame_abort) begin
                fill_n = 0;
            end else begin
                if (e_xfer) begin
                    y = deint(fbuf);
                    for (int r = 0; r < 4; r++) mq.push_back(y[11*r +: 11]);
                    fill_n = 0;
                end
                if (in_valid && e_ready) begin
                    fbuf[4*fill_n +: 4] = in_data;
                    fill_n++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_q_t const_frame(input logic [3:0] v);
        beat_q_t q;
        for (int c = 0; c < 11; c++) q.push_back(v);
        return q;
    endfunction

    function automatic beat_q_t one_hot_col(input int col);
        beat_q_t q;
        for (int c = 0; c < 11; c++) q.push_back((c == col) ? 4'hF : 4'h0);
        return q;
    endfunction

    function automatic beat_q_t count_frame();
        beat_q_t q;
        for (int c = 0; c < 11; c++) q.push_back(4'(c));
        return q;
    endfunction

    task automatic send_beats(input beat_q_t q);
        logic ok;
        int   tries;
        for (int i = 0; i < q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = q[i];
            tries    = 0;
            ok       = 1'b0;
            while (!ok && tries < 200) begin
                @(negedge clk);
                ok = in_ready;
                step();
                tries++;
            end
            if (!ok) begin
                timeout("send_beat");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rows(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 300) begin
            step();
            t++;
        end
        if (got.size() < n) timeout("wait_rows");
    endtask

    task automatic check_rows(input string nm, input int base,
                              input logic [10:0] r0, input logic [10:0] r1,
                              input logic [10:0] r2, input logic [10:0] r3);
        logic [10:0] e[4];
        e[0] = r0; e[1] = r1; e[2] = r2; e[3] = r3;
        for (int i = 0; i < 4; i++) begin
            if (got.size() > base + i) chk(nm, got[base + i], e[i]);
            else timeout(nm);
        end
    endtask

    task automatic reset_outputs_check(input string nm);
        @(negedge clk);
        chk({nm, "_in_ready"}, in_ready, 1'b1);
        chk({nm, "_out_valid"}, out_valid, 1'b0);
        chk({nm, "_out_row"}, out_row, 11'h000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_q_t q;
        int      base;
        logic    done;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        frame_abort = 1'b0;
        out_ready   = 1'b0;

        // Reset state.
        reset_outputs_check("rst");
        @(negedge clk);
        chk("rst_out_row_idx", out_row_idx, 2'd0);
        chk("rst_out_last", out_last, 1'b0);
        step();
        rst = 1'b0;
        reset_outputs_check("post_rst");
        step();

        // Mapping plus latency: row 0 valid two edges after the last input handshake.
        got.delete();
        out_ready = 1'b1;
        send_beats(const_frame(4'b0001));
        @(negedge clk);
        chk("lat_e0_out_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_e1_out_valid", out_valid, 1'b1);
        wait_rows(4);
        check_rows("map_rows", 0, 11'h7FF, 11'h000, 11'h000, 11'h000);

        // Column mapping at both ends.
        got.delete();
        send_beats(one_hot_col(0));
        wait_rows(4);
        check_rows("col0_rows", 0, 11'h001, 11'h001, 11'h001, 11'h001);
        got.delete();
        send_beats(one_hot_col(10));
        wait_rows(4);
        check_rows("col10_rows", 0, 11'h400, 11'h400, 11'h400, 11'h400);

        // Back-to-back frames with no input stalls.
        repeat (4) step();
        got.delete();
        base = stall_cnt;
        q.delete();
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 11; c++) q.push_back(4'(1 << k));
        send_beats(q);
        wait_rows(12);
        chk("b2b_stalls", 32'(stall_cnt - base), 32'd0);
        check_rows("b2b_f0", 0, 11'h7FF, 11'h000, 11'h000, 11'h000);
        check_rows("b2b_f1", 4, 11'h000, 11'h7FF, 11'h000, 11'h000);
        check_rows("b2b_f2", 8, 11'h000, 11'h000, 11'h7FF, 11'h000);

        // Backpressure: stall after row 1 of A while B fills.
        repeat (4) step();
        got.delete();
        base = hs_cnt;
        done = 1'b0;
        fork
            begin
                send_beats(const_frame(4'b0010));
                send_beats(const_frame(4'b1000));
                done = 1'b1;
            end
            begin
                int t;
                t = 0;
                while (hs_cnt < base + 2 && t < 300) begin step(); t++; end
                if (hs_cnt < base + 2) timeout("bp_rows");
                out_ready = 1'b0;
                t = 0;
                while (!done && t < 300) begin step(); t++; end
                if (!done) timeout("bp_fill");
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_full_in_ready", in_ready, 1'b0);
                    chk("bp_hold_row_idx", out_row_idx, 2'd2);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_rows(8);
        check_rows("bp_a", 0, 11'h000, 11'h7FF, 11'h000, 11'h000);
        check_rows("bp_b", 4, 11'h000, 11'h000, 11'h000, 11'h7FF);

        // Abort mid-fill while a stalled drain is in progress.
        repeat (4) step();
        got.delete();
        out_ready = 1'b0;
        send_beats(const_frame(4'b0100));
        q = const_frame(4'hF);
        q = q[0:4];
        send_beats(q);
        in_valid    = 1'b1;
        in_data     = 4'hF;
        frame_abort = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_drain_valid", out_valid, 1'b1);
        step();
        frame_abort = 1'b0;
        in_valid    = 1'b0;
        send_beats(count_frame());
        out_ready = 1'b1;
        wait_rows(8);
        check_rows("abort_drain", 0, 11'h000, 11'h000, 11'h7FF, 11'h000);
        check_rows("abort_next", 4, 11'h2AA, 11'h4CC, 11'h0F0, 11'h700);

        // Reset mid-drain and mid-fill, then a clean frame.
        repeat (4) step();
        got.delete();
        out_ready = 1'b0;
        send_beats(const_frame(4'b0001));
        q = const_frame(4'h5);
        q = q[0:5];
        send_beats(q);
        rst = 1'b1;
        reset_outputs_check("mid_rst");
        step();
        rst = 1'b0;
        reset_outputs_check("mid_post_rst");
        step();
        out_ready = 1'b1;
        send_beats(count_frame());
        wait_rows(4);
        check_rows("rst_next", 0, 11'h2AA, 11'h4CC, 11'h0F0, 11'h700);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
